// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/DM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;
    localparam logic [ARB_BE_W-1:0] ARB_BE_ALL = {ARB_BE_W{1'b1}};

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not served last.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_a,
    output logic gnt_b
);

    // last=1 means side b was served most recently, so a tie favours a
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (last) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory requesters,
// one transaction in flight, with a watchdog that aborts a transaction never acked.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ARB_ADDR_W,
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [BE_W-1:0]  BE_ALL  = {BE_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    arb_state_t          state_r;
    arb_owner_t          owner_r;
    logic                last_dm_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [BE_W-1:0]     mem_be_r;
    logic                if_valid_r;
    logic                if_err_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic                dm_valid_r;
    logic                dm_err_r;
    logic [DATA_W-1:0]   dm_rdata_r;

    logic                pick_if_s;
    logic                pick_dm_s;
    logic                if_gnt_s;
    logic                dm_gnt_s;
    logic                busy_s;
    logic                done_s;
    logic                timeout_s;

    rr_pick2 u_pick (
        .req_a (if_req),
        .req_b (dm_req),
        .last  (last_dm_r),
        .gnt_a (pick_if_s),
        .gnt_b (pick_dm_s)
    );

    // Grants are only ever offered while the port is idle
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (state_r == IDLE) begin
            if_gnt_s = pick_if_s;
            dm_gnt_s = pick_dm_s;
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // Transaction end: an ack wins over a watchdog expiry in the same cycle
    always_comb begin
        busy_s    = (state_r == BUSY_IF) || (state_r == BUSY_DM);
        done_s    = 1'b0;
        timeout_s = 1'b0;
        if (busy_s) begin
            if (mem_ack) begin
                done_s = 1'b1;
            end else if (wait_cnt_r == TO_LAST) begin
                done_s    = 1'b1;
                timeout_s = 1'b1;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // Arbitration FSM, request latches, watchdog and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            owner_r     <= OWN_IF;
            last_dm_r   <= 1'b0;
            wait_cnt_r  <= {CNT_W{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
            if_valid_r  <= 1'b0;
            if_err_r    <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_valid_r  <= 1'b0;
            dm_err_r    <= 1'b0;
            dm_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_valid_r <= 1'b0;
            if_err_r   <= 1'b0;
            dm_valid_r <= 1'b0;
            dm_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (if_gnt_s || dm_gnt_s) begin
                        owner_r     <= dm_gnt_s ? OWN_DM : OWN_IF;
                        last_dm_r   <= dm_gnt_s;
                        wait_cnt_r  <= {CNT_W{1'b0}};
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= dm_gnt_s & dm_we;
                        mem_addr_r  <= dm_gnt_s ? dm_addr : if_addr;
                        mem_wdata_r <= dm_gnt_s ? dm_wdata : {DATA_W{1'b0}};
                        mem_be_r    <= dm_gnt_s ? dm_be : BE_ALL;
                        state_r     <= dm_gnt_s ? BUSY_DM : BUSY_IF;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (done_s) begin
                        mem_req_r <= 1'b0;
                        state_r   <= RESP;
                        if (owner_r == OWN_DM) begin
                            dm_valid_r <= 1'b1;
                            dm_err_r   <= timeout_s;
                            if (timeout_s) begin
                                dm_rdata_r <= {DATA_W{1'b0}};
                            end else if (!mem_we_r) begin
                                dm_rdata_r <= mem_rdata;
                            end else begin
                                dm_rdata_r <= dm_rdata_r;
                            end
                        end else begin
                            if_valid_r <= 1'b1;
                            if_err_r   <= timeout_s;
                            if_rdata_r <= timeout_s ? {DATA_W{1'b0}} : mem_rdata;
                        end
                    end else if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_s;
    assign dm_gnt    = dm_gnt_s;
    assign if_valid  = if_valid_r;
    assign if_err    = if_err_r;
    assign if_rdata  = if_rdata_r;
    assign dm_valid  = dm_valid_r;
    assign dm_err    = dm_err_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: latency, alternation, stores,
// watchdog abort, mid-transaction reset and ack/timeout collision.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_dm, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.is_dm = is_dm;
        r.rdata = rdata;
        r.err   = err;
        sb.push_back(r);
    endtask

    // Called in the cycle the response must appear; also checks the pulse ends next cycle
    task automatic check_resp(input string tag);
        resp_t r;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            r = sb.pop_front();
            check({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, ~r.is_dm});
            check({tag, "_dm_valid"}, {31'd0, dm_valid}, {31'd0, r.is_dm});
            check({tag, "_rdata"}, r.is_dm ? dm_rdata : if_rdata, r.rdata);
            check({tag, "_err"}, {31'd0, r.is_dm ? dm_err : if_err}, {31'd0, r.err});
            check({tag, "_mem_req_off"}, {31'd0, mem_req}, 32'd0);
            tick();
            check({tag, "_pulse_end"}, {30'd0, if_valid, dm_valid}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'd0, mem_req, mem_we, if_valid, if_err, dm_valid, dm_err, 2'b00}, 32'd0);
        check({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rdata"}, if_rdata | dm_rdata, 32'd0);
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // IF only, ack on the second mem_req cycle
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        check("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("t1_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        push_exp(1'b0, 32'h0050_0093, 1'b0);
        tick();
        if_req = 1'b0; if_addr = 32'd0;
        check("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_mem_we", {31'd0, mem_we}, 32'd0);
        check("t1_mem_be", {28'd0, mem_be}, 32'hF);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ack = 1'b0;
        check_resp("t1");

        // Contention after reset: DM first, IF next, then DM again
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
        #1;
        check("t2_tie1_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("t2_tie1_if_gnt", {31'd0, if_gnt}, 32'd0);
        push_exp(1'b1, 32'h1111_2222, 1'b0);
        tick();
        dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        check("t2_busy_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("t2_dm_addr", mem_addr, 32'h300);
        tick();
        mem_ack = 1'b0;
        check("t2_resp_if_gnt", {31'd0, if_gnt}, 32'd0);
        check_resp("t2_dm");
        check("t2_idle_if_gnt", {31'd0, if_gnt}, 32'd1);
        push_exp(1'b0, 32'hAAAA_0001, 1'b0);
        tick();
        if_req = 1'b0;
        check("t2_if_addr", mem_addr, 32'h80);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick();
        mem_ack = 1'b0;
        check_resp("t2_if");
        if_req = 1'b1; if_addr = 32'h84;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        #1;
        check("t2_tie3_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("t2_tie3_if_gnt", {31'd0, if_gnt}, 32'd0);
        push_exp(1'b1, 32'h1111_2222, 1'b0);

        // Store held without ack for five cycles; inputs change underneath
        tick();
        if_req = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
        for (int i = 0; i < 5; i++) begin
            check("t3_mem_req", {31'd0, mem_req}, 32'd1);
            check("t3_mem_we", {31'd0, mem_we}, 32'd1);
            check("t3_mem_addr", mem_addr, 32'h100);
            check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("t3_mem_be", {28'd0, mem_be}, 32'h3);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        check_resp("t3");

        // Watchdog: load never acked
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
        #1;
        check("t4_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        push_exp(1'b1, 32'd0, 1'b1);
        tick();
        dm_req = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("t4_mem_req_held", {31'd0, mem_req}, 32'd1);
            tick();
        end
        check_resp("t4_timeout");
        if_req = 1'b1; if_addr = 32'h44;
        #1;
        check("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
        push_exp(1'b0, 32'h1234_5678, 1'b0);
        tick();
        if_req = 1'b0;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check_resp("t4_if");

        // Reset in the middle of a DM transaction, then a late ack
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_be = 4'hF;
        #1;
        check("t5_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        tick();
        dm_req = 1'b0;
        check("t5_mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
        check_all_zero("t5_in_reset");
        tick();
        mem_ack = 1'b0;
        check_all_zero("t5_late_ack");
        tick();
        check_all_zero("t5_after");

        // Ack lands on the watchdog's final cycle
        if_req = 1'b1; if_addr = 32'h48;
        #1;
        check("t6_if_gnt_idle", {31'd0, if_gnt}, 32'd1);
        push_exp(1'b0, 32'hCAFE_F00D, 1'b0);
        tick();
        if_req = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            check("t6_mem_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check_resp("t6");
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        check("t6_stray_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        check("t6_stray_mem_req", {31'd0, mem_req}, 32'd0);
        check("t6_stray_rdata", if_rdata, 32'hCAFE_F00D);
        tick();
        check("t6_stray_valid2", {30'd0, if_valid, dm_valid}, 32'd0);
        check("t6_sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
